// File: rtl/ram_access_pkg.sv
// -----------------------------------------------------------------------------
// ram_access_pkg
// Shared definitions for the RAM access controller: default bus widths and
// the FSM state encoding (also exported on the controller's dbg_state port).
// Optional feature macro used by the design: RAM_ACCESS_CTRL_RR_EN
// -----------------------------------------------------------------------------
package ram_access_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    ACK     = 3'd4
  } state_t;

endpackage

// File: rtl/ram_access_ctrl_arb2.sv
// -----------------------------------------------------------------------------
// arb2
// Two-input request arbiter used by the RAM access controller while idle.
// Build option: RAM_ACCESS_CTRL_RR_EN
//   defined   -> round robin: on a tie the port other than last_grant wins
//   undefined -> fixed priority: port 0 wins every tie, last_grant is ignored
// Ports:
//   req0, req1   request inputs
//   last_grant   port granted most recently (round robin only)
//   enable       arbitration allowed this cycle (controller idle)
//   grant_valid  a grant is issued this cycle
//   grant_id     winning port, meaningful only with grant_valid
// -----------------------------------------------------------------------------
module arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  input  logic enable,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = enable & (req0 | req1);

`ifdef RAM_ACCESS_CTRL_RR_EN
  // A single request wins outright; a tie goes to the port not served last.
  assign grant_id = (req0 & req1) ? ~last_grant : req1;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant_id          = ~req0 & req1;
`endif

endmodule

// File: rtl/ram_access_ctrl.sv
// -----------------------------------------------------------------------------
// ram_access_ctrl
// Sequencer and two-way arbiter sharing one 16x8 RAM between requester 0
// (CPU) and requester 1 (loader/debug). The controller alone drives the RAM
// address, strobes and data bus.
// Build option: RAM_ACCESS_CTRL_RR_EN (round robin ties; fixed priority to
// port 0 when undefined).
//
// Handshake: a requester raises reqN with weN/addrN/wdataN and holds them
// stable until ackN (one-cycle pulse). It may present a new request in the
// cycle after ackN. Read data appears on rdataN with ackN and is held until
// the next read by the same port.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req/we/addr/wdata N   request from port N
//   ackN, rdataN          completion pulse and read data to port N
//   ram_address, ram_we,
//   ram_re, ram_data      RAM interface (ram_data driven only in WR)
//   busy                  controller not idle
//   dbg_state             current FSM state
// Timing from the request sampled at the end of cycle 0:
//   read  -> RD_ADDR c1, RD_DATA c2, ACK c3
//   write -> WR c1, ACK c2
// -----------------------------------------------------------------------------
module ram_access_ctrl
  import ram_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_we,
  output logic              ram_re,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              busy,
  output state_t            dbg_state
);

  state_t            state;
  logic              grant_q;
  logic [DATA_W-1:0] wdata_q;
  logic              last_grant;
  logic              grant_valid;
  logic              grant_id;

  arb2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant),
    .enable      (state == IDLE),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

`ifdef RAM_ACCESS_CTRL_RR_EN
  // Reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant_valid) begin
      last_grant <= grant_id;
    end
  end
`else
  assign last_grant = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant_q     <= 1'b0;
      ram_address <= '0;
      wdata_q     <= '0;
      // An access aborted by reset leaves the previous read result visible;
      // the read-data registers clear only when reset finds the FSM idle.
      if (state == IDLE) begin
        rdata0 <= '0;
        rdata1 <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            grant_q     <= grant_id;
            ram_address <= grant_id ? addr1 : addr0;
            wdata_q     <= grant_id ? wdata1 : wdata0;
            state       <= (grant_id ? we1 : we0) ? WR : RD_ADDR;
          end
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          // RAM output buffer was loaded at the RD_ADDR edge.
          if (grant_q) begin
            rdata1 <= ram_data;
          end else begin
            rdata0 <= ram_data;
          end
          state <= ACK;
        end
        WR:      state <= ACK;
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of the strobes from the state register.
  assign ram_re    = (state == RD_ADDR) || (state == RD_DATA);
  assign ram_we    = (state == WR);
  assign ack0      = (state == ACK) && !grant_q;
  assign ack1      = (state == ACK) && grant_q;
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign ram_data  = (state == WR) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_access_ctrl
// Bench for ram_access_ctrl with a behavioural 16x8 RAM on the shared bus.
// Honours RAM_ACCESS_CTRL_RR_EN for the expected arbitration order.
// -----------------------------------------------------------------------------
module tb_ram_access_ctrl;
  import ram_access_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, ram_we, ram_re, busy;
  logic [7:0] rdata0, rdata1;
  logic [3:0] ram_address;
  wire  [7:0] ram_data;
  state_t     dbg_state;

  ram_access_ctrl dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .ram_address(ram_address), .ram_we(ram_we), .ram_re(ram_re),
    .ram_data(ram_data), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- behavioural RAM ----------------
  logic [7:0] mem_ram [16];
  logic [7:0] init_val [16];
  logic       ram_init;
  logic [7:0] obuf = 8'h00;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) mem_ram[i] <= init_val[i];
    end else begin
      if (ram_we) mem_ram[ram_address] <= ram_data;
      if (ram_re) obuf <= mem_ram[ram_address];
    end
  end
  assign ram_data = ram_re ? obuf : 8'hzz;

  // ---------------- reference model / scoreboard ----------------
  logic [7:0] mem_ref [16];
  logic [8:0] exp_q0[$];   // bit 8: read, bits 7:0: expected read data
  logic [8:0] exp_q1[$];
  logic       ack_order[$];
  int checks = 0;
  int errors = 0;
  int we_cycles = 0, re_cycles = 0, ack0_cnt = 0, ack1_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    checks++;
    if (ram_we && ram_re) begin
      errors++; $display("FAIL strobe_excl: ram_we=1 ram_re=1, required not both");
    end
    checks++;
    if (ack0 && ack1) begin
      errors++; $display("FAIL ack_excl: ack0=1 ack1=1, required at most one");
    end
    checks++;
    if (busy !== (dbg_state != IDLE)) begin
      errors++; $display("FAIL busy_state: busy=%0b state=%0d", busy, dbg_state);
    end
    checks++;
    if (ram_we !== (dbg_state == WR)) begin
      errors++; $display("FAIL we_only_in_wr: ram_we=%0b state=%0d", ram_we, dbg_state);
    end
    if (ram_we) we_cycles++;
    if (ram_re) re_cycles++;
    if (ack0) begin
      ack0_cnt++;
      ack_order.push_back(1'b0);
      checks++;
      if (exp_q0.size() == 0) begin
        errors++; $display("FAIL ack0_unexpected: ack0=1, required no ack");
      end else begin
        e = exp_q0.pop_front();
        if (e[8] && rdata0 !== e[7:0]) begin
          errors++; $display("FAIL rdata0: got 0x%0h, required 0x%0h", rdata0, e[7:0]);
        end
      end
    end
    if (ack1) begin
      ack1_cnt++;
      ack_order.push_back(1'b1);
      checks++;
      if (exp_q1.size() == 0) begin
        errors++; $display("FAIL ack1_unexpected: ack1=1, required no ack");
      end else begin
        e = exp_q1.pop_front();
        if (e[8] && rdata1 !== e[7:0]) begin
          errors++; $display("FAIL rdata1: got 0x%0h, required 0x%0h", rdata1, e[7:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle after the ack.
  task automatic do_access(input int port, input logic w, input logic [3:0] a,
                           input logic [7:0] d, output int lat);
    logic [8:0] e;
    int start;
    logic got;
    e = {~w, (w ? 8'h00 : mem_ref[a])};
    if (w) mem_ref[a] = d;
    if (port == 0) begin
      exp_q0.push_back(e);
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      exp_q1.push_back(e);
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end
    start = cyc;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = (port == 0) ? ack0 : ack1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout: port %0d got no ack in 60 cycles, required ack", port);
    end
    lat = cyc - start;
    @(posedge clk); #1;
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, w0, r0, a0, a1;
    logic got;
    logic exp_order [8];

    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    for (int i = 0; i < 16; i++) init_val[i] = 8'($urandom_range(0, 255));
    init_val[10] = 8'h03;
    for (int i = 0; i < 16; i++) mem_ref[i] = init_val[i];
    ram_init = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ram_init = 1'b0;
    reset = 1'b0;

    // Reset state
    check("rst_state", dbg_state, IDLE);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_rdata0", rdata0, 8'h00);
    check("rst_rdata1", rdata1, 8'h00);
    check("rst_ram_address", ram_address, 4'h0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_re", ram_re, 0);
    check("rst_busy", busy, 0);

    // Port 0 read of preloaded 0xA
    r0 = re_cycles; a1 = ack1_cnt;
    do_access(0, 1'b0, 4'hA, 8'h00, lat);
    check("t1_read_latency", lat, 3);
    check("t1_re_cycles", re_cycles - r0, 2);
    check("t1_rdata0", rdata0, 8'h03);
    check("t1_no_ack1", ack1_cnt - a1, 0);

    // Port 1 write 0x5A to 0xF, then read it back
    w0 = we_cycles;
    do_access(1, 1'b1, 4'hF, 8'h5A, lat);
    check("t2_write_latency", lat, 2);
    check("t2_we_cycles", we_cycles - w0, 1);
    do_access(1, 1'b0, 4'hF, 8'h00, lat);
    check("t2_read_latency", lat, 3);
    check("t2_rdata1", rdata1, 8'h5A);

    // Port 0 back-to-back write then read, re-presented right after ack
    w0 = we_cycles; r0 = re_cycles; a0 = ack0_cnt;
    do_access(0, 1'b1, 4'h2, 8'h3C, lat);
    do_access(0, 1'b0, 4'h2, 8'h00, lat);
    repeat (4) @(posedge clk);
    #1;
    check("t3_we_cycles", we_cycles - w0, 1);
    check("t3_re_cycles", re_cycles - r0, 2);
    check("t3_ack0_count", ack0_cnt - a0, 2);
    check("t3_rdata0", rdata0, 8'h3C);

    // Reset during RD_DATA of a port 0 read
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'h5;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (dbg_state == RD_DATA);
    end
    check("t4_reach_rd_data", got, 1);
    reset = 1'b1; req0 = 1'b0;
    a0 = ack0_cnt;
    @(posedge clk); #1;
    check("t4_state_idle", dbg_state, IDLE);
    check("t4_busy", busy, 0);
    check("t4_ack0", ack0, 0);
    check("t4_rdata0_kept", rdata0, 8'h3C);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t4_no_ack0", ack0_cnt - a0, 0);

    // Both ports requesting continuously
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ack_order.delete();
    fork
      begin
        int l;
        for (int i = 0; i < 4; i++) do_access(0, 1'b0, 4'h0, 8'h00, l);
      end
      begin
        int l;
        for (int i = 0; i < 4; i++) do_access(1, 1'b0, 4'h1, 8'h00, l);
      end
    join
    for (int i = 0; i < 8; i++) begin
`ifdef RAM_ACCESS_CTRL_RR_EN
      exp_order[i] = 1'(i % 2);
`else
      exp_order[i] = (i >= 4);
`endif
    end
    check("t5_ack_count", ack_order.size(), 8);
    for (int i = 0; i < 8 && i < ack_order.size(); i++)
      check($sformatf("t5_grant_%0d", i), ack_order[i], exp_order[i]);

    // Randomized concurrent traffic; ports use disjoint address halves
    fork
      begin
        int l;
        for (int i = 0; i < 20; i++) begin
          do_access(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                    8'($urandom_range(0, 255)), l);
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
      end
      begin
        int l;
        for (int i = 0; i < 20; i++) begin
          do_access(1, 1'($urandom_range(0, 1)), 4'($urandom_range(8, 15)),
                    8'($urandom_range(0, 255)), l);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
      end
    join

    repeat (6) @(posedge clk);
    #1;
    check("end_exp_q0_empty", exp_q0.size(), 0);
    check("end_exp_q1_empty", exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
